// File: rtl/mem_data_responder_pkg.sv
// Shared types and constants for the MEM-stage data responder.
// Holds the bus widths, enable levels, state encodings and the lane-mask helper.
package mem_data_responder_pkg;

  localparam int WORD_W = 32;
  localparam int SEL_W  = 4;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int MEM_LATENCY_DEFAULT = 2;

  typedef enum logic [1:0] {
    MEM_RESP_IDLE = 2'd0,
    MEM_RESP_WAIT = 2'd1,
    MEM_RESP_RESP = 2'd2
  } mem_resp_state_t;

  // Expands a byte-lane select into a 32-bit mask.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_W; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_data_responder_byte_lane_ram.sv
// Byte-lane word RAM: four 8-bit arrays with per-lane write enables.
// The read port is synchronous and only updates when i_re is asserted.
module byte_lane_ram
  import mem_data_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [SEL_W-1:0]  i_lane_we,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_re,
  output logic [WORD_W-1:0] o_rdata
);

  for (genvar g = 0; g < SEL_W; g++) begin : g_lane
    logic [7:0] r_mem [2**ADDR_W];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_lane_we[g]) begin
        r_mem[i_addr] <= i_wdata[8*g +: 8];
      end
      if (i_re) begin
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[8*g +: 8] = r_q;
  end

endmodule

// File: rtl/mem_data_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY cycles,
// then commits the write or presents masked read data with a one-cycle valid.
module mem_data_responder
  import mem_data_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_we,
  input  logic              i_req_re,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [SEL_W-1:0]  i_req_sel,
  input  logic [WORD_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  output logic [WORD_W-1:0] o_resp_rdata,
  output logic              o_stall_req,
  output logic              o_err_both
);

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  mem_resp_state_t   r_state;
  mem_resp_state_t   w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  r_rsel;
  logic [WORD_W-1:0] r_wdata;
  logic              r_we;
  logic              r_err_both;

  logic              w_req;
  logic              w_accept;
  logic              w_is_read;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [SEL_W-1:0]  w_rsel_src;
  logic [SEL_W-1:0]  w_lane_we;
  logic [WORD_W-1:0] w_ram_q;

  assign w_req    = i_req_we | i_req_re;
  assign w_accept = (r_state == MEM_RESP_IDLE) & w_req;

  // In IDLE the RAM is steered by the live request so a zero-latency read can
  // be captured on the accepting edge; afterwards the latched request drives it.
  always_comb begin
    w_next      = r_state;
    o_stall_req = 1'b0;
    w_is_read   = ~r_we;
    w_ram_addr  = r_addr;
    w_rsel_src  = r_sel;
    w_lane_we   = '0;
    case (r_state)
      MEM_RESP_IDLE: begin
        o_stall_req = w_req;
        w_is_read   = i_req_re & (i_req_we != ENABLE);
        w_ram_addr  = i_req_addr;
        w_rsel_src  = i_req_sel;
        if (w_req) begin
          w_next = (LATENCY == 0) ? MEM_RESP_RESP : MEM_RESP_WAIT;
        end
      end
      MEM_RESP_WAIT: begin
        o_stall_req = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_next = MEM_RESP_RESP;
        end
      end
      MEM_RESP_RESP: begin
        w_next = MEM_RESP_IDLE;
        if ((r_we == ENABLE) && !rst) begin
          w_lane_we = r_sel;
        end
      end
      default: w_next = MEM_RESP_IDLE;
    endcase
    w_ram_re = (w_next == MEM_RESP_RESP) & (r_state != MEM_RESP_RESP) & w_is_read & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= MEM_RESP_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_sel      <= '0;
      r_rsel     <= '0;
      r_wdata    <= '0;
      r_we       <= DISABLE;
      r_err_both <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_err_both <= w_accept & i_req_we & i_req_re;
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_sel   <= i_req_sel;
        r_wdata <= i_req_wdata;
        r_we    <= i_req_we;
        r_cnt   <= LAT4;
      end else if (r_state == MEM_RESP_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // The read mask only moves with the RAM read port, so the output holds.
      if (w_ram_re) begin
        r_rsel <= w_rsel_src;
      end
    end
  end

  byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .i_addr    (w_ram_addr),
    .i_lane_we (w_lane_we),
    .i_wdata   (r_wdata),
    .i_re      (w_ram_re),
    .o_rdata   (w_ram_q)
  );

  assign o_resp_valid = (r_state == MEM_RESP_RESP);
  assign o_resp_rdata = w_ram_q & lane_mask(r_rsel);
  assign o_err_both   = r_err_both;

endmodule

// File: tb/tb_mem_data_responder.sv
// Bench for mem_data_responder: three instances (latency 2, latency 0, 4-bit address)
// checked every cycle against a cycle-count model plus directed literal expectations.
module tb_mem_data_responder;

  logic        clk;
  logic        rst;
  logic [2:0]  we, re, vld, stl, err;
  logic [9:0]  addrs [3];
  logic [3:0]  sels  [3];
  logic [31:0] wdats [3];
  logic [31:0] rdat  [3];

  int chkCnt  = 0;
  int passCnt = 0;
  bit chkEn   = 0;

  int          lat  [3] = '{2, 0, 2};
  int          amsk [3] = '{1023, 1023, 15};
  logic [31:0] mdl  [3][1024];
  bit          busy    [3];
  int          respCyc [3];
  int          errCyc  [3];
  bit          opWe    [3];
  int          opAddr  [3];
  logic [3:0]  opSel   [3];
  logic [31:0] opData  [3];
  logic [31:0] expRd   [3];
  int          cyc = 0;

  mem_data_responder #(.ADDR_W(10), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .i_req_we(we[0]), .i_req_re(re[0]), .i_req_addr(addrs[0]),
    .i_req_sel(sels[0]), .i_req_wdata(wdats[0]), .o_resp_valid(vld[0]),
    .o_resp_rdata(rdat[0]), .o_stall_req(stl[0]), .o_err_both(err[0])
  );

  mem_data_responder #(.ADDR_W(10), .LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .i_req_we(we[1]), .i_req_re(re[1]), .i_req_addr(addrs[1]),
    .i_req_sel(sels[1]), .i_req_wdata(wdats[1]), .o_resp_valid(vld[1]),
    .o_resp_rdata(rdat[1]), .o_stall_req(stl[1]), .o_err_both(err[1])
  );

  mem_data_responder #(.ADDR_W(4), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .i_req_we(we[2]), .i_req_re(re[2]), .i_req_addr(addrs[2][3:0]),
    .i_req_sel(sels[2]), .i_req_wdata(wdats[2]), .o_resp_valid(vld[2]),
    .o_resp_rdata(rdat[2]), .o_stall_req(stl[2]), .o_err_both(err[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] selMask(input logic [3:0] s);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    chkCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s[dut%0d]: got %h, expected %h", name, k, act, exp);
  endtask

  // Model: a request accepted at cycle T completes at cycle T+LATENCY+1;
  // writes land in the model array when that cycle ends, reset drops anything in flight.
  initial begin
    for (int k = 0; k < 3; k++) begin
      busy[k] = 0; errCyc[k] = -1; expRd[k] = 32'h0;
      for (int a = 0; a < 1024; a++) mdl[k][a] = 32'h0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          busy[k] = 0; errCyc[k] = -1; expRd[k] = 32'h0;
        end else if (busy[k]) begin
          if (cyc == respCyc[k]) begin
            busy[k] = 0;
            if (opWe[k]) begin
              for (int i = 0; i < 4; i++)
                if (opSel[k][i]) mdl[k][opAddr[k]][8*i +: 8] = opData[k][8*i +: 8];
            end
          end
        end else if (we[k] | re[k]) begin
          busy[k]    = 1;
          respCyc[k] = cyc + lat[k] + 1;
          errCyc[k]  = (we[k] & re[k]) ? cyc + 1 : -1;
          opWe[k]    = we[k];
          opAddr[k]  = int'(addrs[k]) & amsk[k];
          opSel[k]   = sels[k];
          opData[k]  = wdats[k];
        end
      end
      cyc++;
    end
  end

  // Compare every instance's outputs with the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chkEn) begin
        for (int k = 0; k < 3; k++) begin
          logic eStall, eValid, eErr;
          if (busy[k] && cyc == respCyc[k] && !opWe[k])
            expRd[k] = mdl[k][opAddr[k]] & selMask(opSel[k]);
          eStall = busy[k] ? (cyc < respCyc[k]) : (we[k] | re[k]);
          eValid = busy[k] && (cyc == respCyc[k]);
          eErr   = (cyc == errCyc[k]);
          checkOutput("stall_req",  k, {31'd0, stl[k]}, {31'd0, eStall});
          checkOutput("resp_valid", k, {31'd0, vld[k]}, {31'd0, eValid});
          checkOutput("err_both",   k, {31'd0, err[k]}, {31'd0, eErr});
          checkOutput("resp_rdata", k, rdat[k], expRd[k]);
        end
      end
    end
  end

  // Holds one request until its response, then releases it after the next edge.
  task automatic applyStimulus(input int k, input logic w, input logic r, input logic [9:0] a,
                               input logic [3:0] s, input logic [31:0] d, output int latObs,
                               output int stalls, output int errs, output logic [31:0] rd);
    int n;
    bit done;
    n = 0; done = 0; latObs = -1; stalls = 0; errs = 0; rd = 32'h0;
    we[k] = w; re[k] = r; addrs[k] = a; sels[k] = s; wdats[k] = d;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (stl[k]) stalls++;
      if (err[k]) errs++;
      if (vld[k]) begin
        done = 1; latObs = n - 1; rd = rdat[k];
      end
    end
    @(posedge clk);
    #1;
    we[k] = 1'b0; re[k] = 1'b0;
    if (!done) checkOutput("resp_timeout", k, 32'd0, 32'd1);
  endtask

  initial begin
    int l, st, er;
    logic [31:0] rd;
    rst = 1'b1; we = '0; re = '0;
    for (int k = 0; k < 3; k++) begin
      addrs[k] = '0; sels[k] = '0; wdats[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chkEn = 1;

    @(negedge clk);
    checkOutput("reset_rdata", 0, rdat[0], 32'h0);
    checkOutput("reset_stall", 0, {31'd0, stl[0]}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(0, 1, 0, 10'd5, 4'b1111, 32'hDEADBEEF, l, st, er, rd);
    checkOutput("wr_latency", 0, l, 3);
    checkOutput("wr_stalls", 0, st, 3);
    applyStimulus(0, 0, 1, 10'd5, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("rd_full", 0, rd, 32'hDEADBEEF);

    applyStimulus(0, 1, 0, 10'd5, 4'b0010, 32'h0000AA00, l, st, er, rd);
    applyStimulus(0, 0, 1, 10'd5, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("rd_merged", 0, rd, 32'hDEADAAEF);
    applyStimulus(0, 0, 1, 10'd5, 4'b0001, 32'h0, l, st, er, rd);
    checkOutput("rd_lane0", 0, rd, 32'h000000EF);

    applyStimulus(1, 1, 0, 10'd3, 4'b1111, 32'hCAFEF00D, l, st, er, rd);
    applyStimulus(1, 0, 1, 10'd3, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("lat0_latency", 1, l, 1);
    checkOutput("lat0_stalls", 1, st, 1);
    checkOutput("lat0_rdata", 1, rd, 32'hCAFEF00D);

    applyStimulus(0, 1, 1, 10'd7, 4'b1111, 32'h12345678, l, st, er, rd);
    checkOutput("both_err", 0, er, 1);
    checkOutput("both_rdata_held", 0, rd, 32'h000000EF);
    applyStimulus(0, 0, 1, 10'd7, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("both_written", 0, rd, 32'h12345678);

    applyStimulus(0, 1, 0, 10'd9, 4'b1111, 32'h11111111, l, st, er, rd);
    we[0] = 1'b1; addrs[0] = 10'd9; sels[0] = 4'b1111; wdats[0] = 32'h22222222;
    @(posedge clk);
    #1;
    we[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("abort_valid", 0, {31'd0, vld[0]}, 32'd0);
      checkOutput("abort_stall", 0, {31'd0, stl[0]}, 32'd0);
      checkOutput("abort_err", 0, {31'd0, err[0]}, 32'd0);
      checkOutput("abort_rdata", 0, rdat[0], 32'h0);
    end
    @(posedge clk);
    #1;
    applyStimulus(0, 0, 1, 10'd9, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("abort_kept_old", 0, rd, 32'h11111111);

    applyStimulus(2, 1, 0, 10'h00F, 4'b1111, 32'hAAAA5555, l, st, er, rd);
    applyStimulus(2, 1, 0, 10'h000, 4'b1111, 32'h0BADC0DE, l, st, er, rd);
    applyStimulus(2, 0, 1, 10'h00F, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("wrap_top", 2, rd, 32'hAAAA5555);
    applyStimulus(2, 0, 1, 10'h000, 4'b1111, 32'h0, l, st, er, rd);
    checkOutput("wrap_zero", 2, rd, 32'h0BADC0DE);
    checkOutput("b2b_latency", 2, l, 3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCnt, chkCnt);
    $finish;
  end

endmodule
